ram_stream_reader: RTL
======================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, giving the RAM word-address width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 3, giving the output buffer depth in 32-bit words (minimum 3).
REQ-003 clk  in  1  single clock for all logic, same clock as the RAM read port.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a burst; sampled only when busy=0.
REQ-006 base_addr  in  ADDR_WIDTH  first word address; sampled with start.
REQ-007 length  in  ADDR_WIDTH+1  number of words to read; sampled with start.
REQ-008 busy  out  1  high from start acceptance until done.
REQ-009 done  out  1  one-cycle pulse at burst completion.
REQ-010 ram_addr  out  ADDR_WIDTH  read address to the RAM read port.
REQ-011 ram_rdata  in  32  RAM read data, valid one cycle after ram_addr is sampled.
REQ-012 out_data  out  32  stream data word.
REQ-013 out_valid  out  1  stream word valid.
REQ-014 out_ready  in  1  stream sink ready; a transfer occurs on a clock edge with out_valid=1 and out_ready=1.
REQ-015 out_last  out  1  high with the final word of the burst.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DRAIN.
- IDLE -> RUN on start with length>0.
- IDLE -> IDLE on start with length=0; done pulses on the following cycle; no stream output.
- RUN -> DRAIN when the last read has been issued.
- DRAIN -> IDLE on the transfer of the out_last word; done pulses the cycle after that transfer.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 A read SHALL be issued in a cycle only when state=RUN and fifo_count + inflight < FIFO_DEPTH.
- Count fifo_count after this cycle's pop.
- ram_addr carries the issued address during that cycle.
- Issuing increments the address counter.
REQ-019 The block SHALL track inflight, a 1-bit flag marking a read issued in the previous cycle. The RAM data for that read SHALL be written into the FIFO at the end of the following cycle.
REQ-020 The address SHALL increment modulo 2^ADDR_WIDTH, so a burst crossing the top of memory wraps to 0.
REQ-021 Latency: with start accepted at edge E0, ram_addr=base_addr during the cycle after E0, and out_valid SHALL rise after edge E0+2.
REQ-022 With out_ready held at 1, the block SHALL sustain one word per cycle until the burst ends.
REQ-023 With out_ready=0, out_data, out_valid and out_last SHALL hold stable. Issuing SHALL stall once the FIFO plus inflight reach FIFO_DEPTH, and no word is lost or duplicated.
REQ-024 Words SHALL be delivered in ascending address order. Exactly length words are delivered, and out_last is set only on the final one.
REQ-025 While idle, ram_addr SHALL hold its last value. The RAM reads continuously; rdata from unissued cycles SHALL be discarded.
REQ-026 A FIFO push and pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full or holds exactly one word.

Reset
REQ-027 While rst=1, all of the following SHALL be 0: state (IDLE), busy, done, out_valid, out_last, ram_addr, out_data, fifo_count, inflight and all counters.
REQ-028 A reset asserted mid-burst SHALL abort the burst and flush the FIFO. No done pulse SHALL follow, and a new start is accepted on the first edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/RUN/DRAIN) and the default FIFO_DEPTH constant.
REQ-030 The output buffer SHALL be one sub-module, stream_fifo: synchronous, FIFO_DEPTH x 33 bits (data plus last flag), with count output, same clk/rst.

Verification
REQ-031 Scenario: base=0x0010, length=4, out_ready=1 -> out_valid rises 2 edges after start; words from 0x10..0x13 are delivered in consecutive cycles; out_last on the 4th; done one cycle later.
REQ-032 Scenario: length=0 -> busy stays low, done pulses once, no out_valid.
REQ-033 Scenario: base=0xFFFE, length=4 -> words from 0xFFFE, 0xFFFF, 0x0000, 0x0001 are delivered in order.
REQ-034 Scenario: length=16, out_ready toggled randomly, held low 10 cycles mid-burst -> all 16 words delivered in order, outputs stable while stalled, at most FIFO_DEPTH words buffered.
REQ-035 Scenario: second start during busy -> ignored; only the first burst is delivered.
REQ-036 Scenario: rst asserted after 3 of 8 words -> all outputs 0 immediately; no done; a new burst base=0x0100, length=2 afterwards completes normally.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader.
//   state_t            : burst controller states
//   DEFAULT_FIFO_DEPTH : default output buffer depth in 32-bit words (min 3)
//   DATA_W             : RAM / stream data width
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_FIFO_DEPTH = 3;
    localparam int DATA_W             = 32;

endpackage

// File: rtl/ram_stream_reader_stream_fifo.sv
// stream_fifo: small synchronous FIFO used as the reader's output buffer.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the end of this cycle
//   push_data  : {last, data} word to store
//   pop        : consume the head word at the end of this cycle
//   head_data  : current head word, zero when empty
//   count      : number of stored words
// A push and a pop in the same cycle leave count unchanged, also when full.
module stream_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter  int WIDTH = DATA_W + 1,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ptr_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_inc(rd_q);
        end
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Gate the head so the stream outputs read as zero whenever nothing is stored.
    assign head_data = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count     = cnt_q;

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of consecutive words from a synchronous
// RAM (one-cycle read latency) and streams them out with valid/ready.
//   clk, rst            : clock, asynchronous active-high reset
//   start, base_addr,
//   length              : burst request, sampled only while idle
//   busy, done          : burst in progress / one-cycle completion pulse
//   ram_addr, ram_rdata : RAM read port
//   out_data, out_valid,
//   out_ready, out_last : output stream, out_last marks the final word
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;          // next address to issue
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;  // last issued address
    logic [ADDR_WIDTH:0]   rem_q, rem_d;            // reads still to issue
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;

    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_W:0]       head;
    logic                  pop;
    logic                  issue;

    assign out_valid = (fifo_count != '0);
    assign out_data  = head[DATA_W-1:0];
    assign out_last  = head[DATA_W];
    assign pop       = out_valid && out_ready;

    // Space check uses the count after this cycle's pop plus the read whose
    // data lands at the end of this cycle, so the FIFO can never overflow.
    assign issue = (state_q == RUN) &&
                   ((int'(fifo_count) - int'(pop) + int'(inflight_q)) < FIFO_DEPTH);

    // The issued address goes straight out; otherwise hold the last one.
    assign ram_addr = issue ? addr_q : ram_addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        ram_addr_d      = ram_addr_q;
        rem_d           = rem_q;
        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == ONE);
        done_d          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        addr_d  = base_addr;
                        rem_d   = length;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d     = addr_q + 1'b1;  // wraps at the top of memory
                    ram_addr_d = addr_q;
                    rem_d      = rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            ram_addr_q      <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            ram_addr_q      <= ram_addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    // RAM data is only captured for the cycle after an issue; other cycles'
    // rdata is dropped.
    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, ram_rdata}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

endmodule
